// File: rtl/frag_uart_dump_tx.sv
// Dumps WORDS 32-bit words from a synchronous-read data memory over a UART
// line, little-endian byte order, 8N1 framing, LSB first.
module frag_uart_dump_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int WORDS        = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start_i,
    output logic        rd_en_o,
    output logic [4:0]  rd_addr_o,
    input  logic [31:0] rd_data_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    WORD_LAST = 5'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [1:0]    byte_idx_reg, byte_idx_next;
    logic [4:0]    word_idx_reg, word_idx_next;
    logic [31:0]   shift_reg, shift_next;
    logic          tx_reg, tx_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          rd_en_reg, rd_en_next;
    logic [4:0]    rd_addr_reg, rd_addr_next;

    logic [31:0]   shift_shr;
    logic          bit_end;

    // Shifting right once per data bit walks the word out byte 0 first, LSB first.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_shr
            if (gi == 31) begin : g_top
                assign shift_shr[gi] = 1'b0;
            end else begin : g_mid
                assign shift_shr[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    assign bit_end = (cnt_reg == CNT_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            word_idx_reg <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_en_reg    <= 1'b0;
            rd_addr_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            word_idx_reg <= word_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            rd_en_reg    <= rd_en_next;
            rd_addr_reg  <= rd_addr_next;
        end
    end

    // Outputs are registered: each *_next is the value for the state being entered.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        word_idx_next = word_idx_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        rd_en_next    = 1'b0;
        rd_addr_next  = rd_addr_reg;

        case (state_reg)
            S_IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                // A request landing while done_o is still high is dropped.
                if (start_i && !done_reg) begin
                    state_next    = S_READ;
                    word_idx_next = '0;
                    busy_next     = 1'b1;
                    rd_en_next    = 1'b1;
                    rd_addr_next  = '0;
                end
            end

            S_READ: begin
                state_next = S_LOAD;
            end

            S_LOAD: begin
                shift_next    = rd_data_i;
                byte_idx_next = '0;
                bit_idx_next  = '0;
                cnt_next      = '0;
                tx_next       = 1'b0;
                state_next    = S_START;
            end

            S_START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    tx_next    = shift_reg[0];
                    state_next = S_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    shift_next = shift_shr;
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = '0;
                        tx_next      = 1'b1;
                        state_next   = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (byte_idx_reg != 2'd3) begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                        tx_next       = 1'b0;
                        state_next    = S_START;
                    end else if (word_idx_reg != WORD_LAST) begin
                        word_idx_next = word_idx_reg + 1'b1;
                        rd_en_next    = 1'b1;
                        rd_addr_next  = word_idx_reg + 1'b1;
                        tx_next       = 1'b1;
                        state_next    = S_READ;
                    end else begin
                        tx_next    = 1'b1;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign tx_o      = tx_reg;
    assign busy_o    = busy_reg;
    assign done_o    = done_reg;
    assign rd_en_o   = rd_en_reg;
    assign rd_addr_o = rd_addr_reg;

endmodule

// File: tb/tb_frag_uart_dump_tx.sv
// Directed bench for frag_uart_dump_tx: decodes the UART line, logs memory
// reads and done pulses, and compares against hand-computed expectations.
module tb_frag_uart_dump_tx;

    localparam int C        = 4;
    localparam int W        = 32;
    localparam int DUMP_CYC = W * (2 + 40 * C);

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start_i = 1'b0;
    logic        rd_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mem [0:31];
    logic [7:0]  rx_q[$];
    int          rx_t[$];
    int          rx_bad = 0;
    int          addr_q[$];
    int          done_q[$];

    frag_uart_dump_tx #(.CLKS_PER_BIT(C), .WORDS(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start_i   (start_i),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 sys_clk = ~sys_clk;

    // Memory model: word valid one cycle after rd_en_o, junk otherwise.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (rd_en_o === 1'b1) rd_data_i <= mem[rd_addr_o];
        else                  rd_data_i <= 32'hDEAD_BEEF;
    end

    always @(negedge sys_clk) begin
        if (rd_en_o === 1'b1) addr_q.push_back(int'(rd_addr_o));
        if (done_o === 1'b1)  done_q.push_back(cyc);
    end

    // UART decoder: every sample of each bit must agree with the first one.
    initial begin : uart_rx
        logic [7:0] b;
        bit         ok;
        int         t_s;
        forever begin
            @(negedge sys_clk);
            if (sys_rst === 1'b0 && tx_o === 1'b0) begin
                t_s = cyc;
                ok  = 1'b1;
                b   = 8'h00;
                for (int k = 1; k < C; k++) begin
                    @(negedge sys_clk);
                    if (tx_o !== 1'b0) ok = 1'b0;
                end
                for (int i = 0; i < 8; i++) begin
                    for (int k = 0; k < C; k++) begin
                        @(negedge sys_clk);
                        if (k == 0) b[i] = tx_o;
                        else if (tx_o !== b[i]) ok = 1'b0;
                    end
                end
                for (int k = 0; k < C; k++) begin
                    @(negedge sys_clk);
                    if (tx_o !== 1'b1) ok = 1'b0;
                end
                rx_q.push_back(b);
                rx_t.push_back(t_s);
                if (!ok) rx_bad++;
            end
        end
    end

    task automatic clear_logs();
        rx_q.delete();
        rx_t.delete();
        addr_q.delete();
        done_q.delete();
        rx_bad = 0;
    endtask

    task automatic pulse_start(output int t0);
        @(negedge sys_clk);
        start_i = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int n = 0;
        while (done_o !== 1'b1 && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        ok = (done_o === 1'b1);
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < 32; a++) mem[a] = 32'hA500_0000 | 32'(a);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            checks++;
            if ({tx_o, busy_o, done_o, rd_en_o} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: tx/busy/done/rd_en got %b want 1000",
                         i, {tx_o, busy_o, done_o, rd_en_o});
            end
        end
        checks++;
        if (rd_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d want 0", rd_addr_o);
        end
    endtask

    task automatic test_byte_order();
        logic [7:0] expb [4];
        int t0;
        int n = 0;
        expb = '{8'h78, 8'h56, 8'h34, 8'h12};
        fill_pattern();
        mem[0] = 32'h1234_5678;
        clear_logs();
        pulse_start(t0);
        checks++;
        if ({busy_o, rd_en_o, rd_addr_o} !== {2'b11, 5'd0}) begin
            errors++;
            $display("FAIL accept: busy/rd_en/addr got %b/%b/%0d want 1/1/0", busy_o, rd_en_o, rd_addr_o);
        end
        while (rx_q.size() < 4 && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        if (rx_q.size() < 4) begin
            errors++;
            $display("FAIL byte_order_timeout: got %0d bytes want 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[i] !== expb[i]) begin
                    errors++;
                    $display("FAIL byte_order[%0d]: got %02h want %02h", i, rx_q[i], expb[i]);
                end
            end
            checks++;
            if (rx_t[0] != t0 + 2) begin
                errors++;
                $display("FAIL first_start_bit: got cycle %0d want %0d", rx_t[0], t0 + 2);
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (rx_t[i] - rx_t[i-1] != 40) begin
                    errors++;
                    $display("FAIL frame_len[%0d]: got %0d want 40", i, rx_t[i] - rx_t[i-1]);
                end
            end
        end
        checks++;
        if (rx_bad != 0) begin
            errors++;
            $display("FAIL framing: got %0d bad frames want 0", rx_bad);
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (50) @(negedge sys_clk);
    endtask

    task automatic test_full_dump();
        int t0;
        int nbad;
        bit ok;
        logic [31:0] tmp;
        fill_pattern();
        clear_logs();
        pulse_start(t0);
        wait_done(DUMP_CYC + 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_done_timeout: got no done want done at %0d", t0 + DUMP_CYC);
        end else begin
            checks++;
            if (cyc != t0 + DUMP_CYC) begin
                errors++;
                $display("FAIL full_done_time: got %0d cycles want %0d", cyc - t0, DUMP_CYC);
            end
            @(negedge sys_clk);
            checks++;
            if ({done_o, busy_o, tx_o} !== 3'b001 || done_q.size() != 1) begin
                errors++;
                $display("FAIL done_width: done/busy/tx got %b pulses %0d want 001 pulses 1",
                         {done_o, busy_o, tx_o}, done_q.size());
            end
        end
        nbad = 0;
        for (int i = 0; i < 32; i++) if (i >= addr_q.size() || addr_q[i] != i) nbad++;
        checks++;
        if (addr_q.size() != 32 || nbad != 0) begin
            errors++;
            $display("FAIL full_addr_seq: got %0d reads %0d wrong want 32 reads 0..31", addr_q.size(), nbad);
        end
        nbad = 0;
        for (int k = 0; k < 128; k++) begin
            tmp = (32'hA500_0000 | 32'(k / 4)) >> (8 * (k % 4));
            if (k >= rx_q.size() || rx_q[k] !== tmp[7:0]) nbad++;
        end
        checks++;
        if (rx_q.size() != 128 || nbad != 0 || rx_bad != 0) begin
            errors++;
            $display("FAIL full_bytes: got %0d bytes %0d wrong %0d bad frames want 128 0 0",
                     rx_q.size(), nbad, rx_bad);
        end
        nbad = 0;
        for (int k = 1; k < rx_t.size(); k++)
            if (rx_t[k] - rx_t[k-1] != ((k % 4 == 0) ? 42 : 40)) nbad++;
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL full_spacing: got %0d wrong gaps want 0", nbad);
        end
    endtask

    task automatic test_start_while_busy();
        int t0;
        int nbad;
        int n = 0;
        bit ok;
        fill_pattern();
        clear_logs();
        pulse_start(t0);
        while (addr_q.size() < 6 && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (20) @(negedge sys_clk);
        start_i = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
        wait_done(DUMP_CYC + 100, ok);
        checks++;
        if (!ok || cyc != t0 + DUMP_CYC) begin
            errors++;
            $display("FAIL busy_done_time: got %0d cycles (seen %0d) want %0d", cyc - t0, ok, DUMP_CYC);
        end
        nbad = 0;
        for (int i = 0; i < 32; i++) if (i >= addr_q.size() || addr_q[i] != i) nbad++;
        checks++;
        if (addr_q.size() != 32 || nbad != 0) begin
            errors++;
            $display("FAIL busy_addr_seq: got %0d reads %0d wrong want 32 reads 0..31", addr_q.size(), nbad);
        end
        checks++;
        if (rx_q.size() != 128 || rx_bad != 0) begin
            errors++;
            $display("FAIL busy_bytes: got %0d bytes %0d bad want 128 0", rx_q.size(), rx_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] expb [4];
        int t0;
        int nbad;
        int n = 0;
        bit ok;
        expb = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
        fill_pattern();
        clear_logs();
        pulse_start(t0);
        while (addr_q.size() < 4 && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (11) @(negedge sys_clk);
        checks++;
        if (busy_o !== 1'b1 || addr_q.size() != 4) begin
            errors++;
            $display("FAIL mid_setup: busy got %b reads %0d want 1 and 4", busy_o, addr_q.size());
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        checks++;
        if ({tx_o, busy_o, rd_en_o} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset: tx/busy/rd_en got %b want 100", {tx_o, busy_o, rd_en_o});
        end
        sys_rst = 1'b0;
        nbad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (done_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL mid_quiet: got %0d active cycles want 0", nbad);
        end
        mem[0] = 32'h0BAD_F00D;
        clear_logs();
        pulse_start(t0);
        checks++;
        if ({busy_o, rd_en_o, rd_addr_o} !== {2'b11, 5'd0}) begin
            errors++;
            $display("FAIL mid_restart: busy/rd_en/addr got %b/%b/%0d want 1/1/0", busy_o, rd_en_o, rd_addr_o);
        end
        wait_done(DUMP_CYC + 100, ok);
        checks++;
        if (!ok || cyc != t0 + DUMP_CYC || addr_q.size() != 32) begin
            errors++;
            $display("FAIL mid_redump: got %0d cycles %0d reads want %0d cycles 32 reads",
                     cyc - t0, addr_q.size(), DUMP_CYC);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q.size() < 4 || rx_q[i] !== expb[i]) begin
                errors++;
                $display("FAIL mid_byte[%0d]: got %02h want %02h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, expb[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        bit ok;
        fill_pattern();
        clear_logs();
        pulse_start(t0);
        wait_done(DUMP_CYC + 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_first_done: got none want done");
        end
        addr_q.delete();
        pulse_start(t1);
        checks++;
        if ({busy_o, rd_en_o, rd_addr_o} !== {2'b11, 5'd0}) begin
            errors++;
            $display("FAIL b2b_accept: busy/rd_en/addr got %b/%b/%0d want 1/1/0", busy_o, rd_en_o, rd_addr_o);
        end
        wait_done(DUMP_CYC + 100, ok);
        checks++;
        if (!ok || cyc != t1 + DUMP_CYC || addr_q.size() != 32) begin
            errors++;
            $display("FAIL b2b_second: got %0d cycles %0d reads want %0d cycles 32 reads",
                     cyc - t1, addr_q.size(), DUMP_CYC);
        end
    endtask

    initial begin
        test_reset();
        test_byte_order();
        test_full_dump();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frag_uart_dump_tx.md
FRAG_UART_DUMP_TX -- requirements
Module: frag_uart_dump_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning sys_clk cycles per UART bit (legal range 2 or more).
REQ-002 SHALL have parameter WORDS, default 32, meaning the number of data-memory words dumped per run (range 1 to 32).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port start_i, input, 1 bit: dump request, sampled every cycle.
REQ-007 SHALL have port rd_en_o, output, 1 bit: data-memory read strobe.
REQ-008 SHALL have port rd_addr_o, output, 5 bits: data-memory word address.
REQ-009 SHALL have port rd_data_i, input, 32 bits: read word, valid on the cycle after rd_en_o.
REQ-010 SHALL have port tx_o, output, 1 bit: UART serial line, idle high.
REQ-011 SHALL have port busy_o, output, 1 bit: a dump is in progress.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle pulse at the end of a dump.

Function
REQ-013 SHALL implement the states IDLE, READ, LOAD, START, DATA, STOP; all outputs are registered.
REQ-014 SHALL, in IDLE with start_i high at a rising edge, enter READ with the word index at 0 and busy_o at 1.
REQ-015 SHALL ignore start_i whenever the state is not IDLE; there is no queuing and no restart.
REQ-016 SHALL, in READ (exactly 1 cycle), drive rd_en_o=1 and rd_addr_o=word index, then go to LOAD.
REQ-017 SHALL, in LOAD (exactly 1 cycle), capture rd_data_i into a 32-bit shift word, set the byte index to 0, then go to START.
REQ-018 SHALL hold rd_en_o at 0 in every state except READ; rd_addr_o holds its last value outside READ.
REQ-019 SHALL, in START, drive tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-020 SHALL, in DATA, send 8 bits LSB first, CLKS_PER_BIT cycles each, then go to STOP.
REQ-021 SHALL, in STOP, drive tx_o=1 for CLKS_PER_BIT cycles.
REQ-022 SHALL send the bytes of each word little-endian: bits [7:0] first, then [15:8], [23:16], [31:24].
REQ-023 SHALL, at the end of STOP, branch as follows:
- byte index < 3: increment the byte index, go to START.
- byte index = 3 and word index < WORDS-1: increment the word index, go to READ.
- otherwise: go to IDLE, set busy_o=0, pulse done_o=1 for exactly 1 cycle.
REQ-024 SHALL have no gap cycles between consecutive bytes of one word (stop bit followed directly by the next start bit).
REQ-025 SHALL insert exactly 2 cycles at tx_o=1 (READ, LOAD) between the last stop bit of one word and the first start bit of the next word.
REQ-026 SHALL take exactly WORDS*(2+40*CLKS_PER_BIT) cycles per dump, from the edge that accepts start_i to the edge that raises done_o.
REQ-027 SHALL use a bit-period counter of width ceil(log2(CLKS_PER_BIT)); it counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-028 SHALL capture each word once in LOAD, so rd_data_i changes outside LOAD do not alter transmitted bytes.
REQ-029 SHALL, in IDLE, drive tx_o=1; a start_i in the same cycle as done_o is ignored, and one in the following cycle is accepted.

Reset
REQ-030 SHALL, on sys_rst high at a rising edge, set state=IDLE, tx_o=1, busy_o=0, done_o=0, rd_en_o=0, rd_addr_o=0, and all counters and the shift word to 0.
REQ-031 SHALL, when reset arrives mid-frame, return tx_o to 1 at that edge without finishing the byte, and not pulse done_o.
REQ-032 SHALL give sys_rst priority over start_i in the same cycle.

Verification (CLKS_PER_BIT=4, WORDS=32; memory model returns word[a] one cycle after rd_en_o)
REQ-033 SHALL check reset idle: sys_rst held 3 cycles, then released -> tx_o=1, busy_o=0, done_o=0, rd_en_o=0 for 20 cycles.
REQ-034 SHALL check byte order: word[0]=0x12345678 -> bytes decoded from tx_o are 0x78, 0x56, 0x34, 0x12, each frame 40 cycles, start bit 0 and stop bit 1.
REQ-035 SHALL check full dump: word[a]=0xA5000000|a -> 128 bytes decoded in address order; rd_addr_o runs 0..31; done_o rises exactly 5184 cycles after start_i is accepted and is high for 1 cycle.
REQ-036 SHALL check start while busy: start_i pulsed during word 5 -> no restart; rd_addr_o sequence and done_o timing unchanged.
REQ-037 SHALL check reset mid-operation: sys_rst during a DATA bit of word 3 -> next cycle tx_o=1, busy_o=0; a new start_i then dumps again from address 0.
REQ-038 SHALL check back-to-back runs: start_i one cycle after done_o -> a second dump begins, with rd_en_o high the following cycle at address 0.
